game_ctrl: RTL
==============

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 4'd9; score that ends the match (legal range 1..15).
REQ-002 Parameter SERVE_FRAMES, default 60; frame ticks the ball is held at centre before each serve (legal range 1..1023).
REQ-003 clk  input  1  system clock; one clock; all state in this domain.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 timing_tick  input  1  one-cycle pulse, once per video frame.
REQ-006 start  input  1  level from the start button; already synchronous to clk.
REQ-007 miss_left  input  1  one-cycle pulse: ball passed player1's paddle (player2 scores).
REQ-008 miss_right  input  1  one-cycle pulse: ball passed player2's paddle (player1 scores).
REQ-009 state  output  2  game state: IDLE=0, PLAY=1, SERVE=2, OVER=3.
REQ-010 player1_score  output  4  player1 points.
REQ-011 player2_score  output  4  player2 points.
REQ-012 ball_rst  output  1  high: ball datapath holds the ball at centre.
REQ-013 serve_dir  output  1  0 = serve toward player1 (left), 1 = toward player2 (right).
REQ-014 winner  output  1  0 = player1, 1 = player2; meaningful only in OVER.

Function
REQ-015 All outputs SHALL be registered; there is no combinational path from input to output.
REQ-016 Start edge: start_q SHALL register start; start_rise = start & ~start_q; start_q resets to 1, so a button held through reset does not trigger.
REQ-017 IDLE: ball_rst=1; scores=0; start_rise -> SERVE, serve_dir=1, serve counter loaded with SERVE_FRAMES-1.
REQ-018 SERVE: ball_rst=1; on each timing_tick, if counter==0 -> PLAY, else counter decrements.
REQ-019 SERVE timing: PLAY SHALL be entered on the clock edge of the SERVE_FRAMES-th timing_tick after SERVE entry.
REQ-020 PLAY: ball_rst=0.
REQ-021 PLAY, miss_left only: player2_score+1, serve_dir=0.
REQ-022 PLAY, miss_right only: player1_score+1, serve_dir=1.
REQ-023 Point end: if the incremented score equals WIN_SCORE -> OVER with winner set to the scorer; else -> SERVE with counter reloaded.
REQ-024 PLAY, miss_left and miss_right in the same cycle: no score change; serve_dir toggles; -> SERVE with counter reloaded.
REQ-025 OVER: ball_rst=1; scores and winner hold.
REQ-026 OVER, start_rise: both scores cleared, serve_dir=1, -> SERVE with counter loaded, in one cycle.
REQ-027 miss_left/miss_right outside PLAY SHALL be ignored; start_rise in SERVE or PLAY SHALL be ignored.
REQ-028 Scores SHALL never exceed WIN_SCORE; no wrap-around is possible.
REQ-029 timing_tick has no effect in IDLE, PLAY or OVER.

Reset
REQ-030 While rst is high: state=IDLE, scores=0, ball_rst=1, serve_dir=1, winner=0, counter=0, start_q=1.
REQ-031 Assertion mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-032 The first transition after rst deasserts requires a fresh start_rise.

Structure
REQ-033 Package game_pkg SHALL hold typedef game_state_t (2-bit enum, values of REQ-009) and default constants WIN_SCORE_DEF and SERVE_FRAMES_DEF.
REQ-034 The top-level datapath SHALL import game_pkg so that it decodes state identically.
REQ-035 Sub-module serve_timer (10-bit loadable down-counter: load, tick, done) SHALL implement REQ-018/019; everything else is in game_ctrl.

Verification (bench uses WIN_SCORE=3, SERVE_FRAMES=3)
REQ-036 rst pulse with start held high, then release rst -> state stays 0 until start falls then rises; next cycle state=2, ball_rst=1, serve_dir=1.
REQ-037 Serve delay: in SERVE, apply 3 timing_tick pulses 10 cycles apart -> state=2 after the 2nd tick, state=1 after the 3rd, ball_rst=0.
REQ-038 Three miss_right pulses, each followed by the serve delay -> player1_score 1,2,3; after the 3rd, state=3, winner=0, ball_rst=1; further misses leave scores at 3/0.
REQ-039 In PLAY with serve_dir=1, miss_left and miss_right in the same cycle -> scores unchanged, serve_dir=0, state=2.
REQ-040 In PLAY with player2_score=2, assert rst asynchronously between clock edges -> outputs reach reset values before the next edge; then start_rise -> state=2 with scores 0/0.
REQ-041 In OVER, start_rise -> next cycle state=2, both scores 0, serve_dir=1; a miss_left pulse during this SERVE -> no score change.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game state encoding and default match parameters for the game
// controller and anything that decodes its state output.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam logic [3:0] WIN_SCORE_DEF    = 4'd9;
    localparam int         SERVE_FRAMES_DEF = 60;

    function automatic logic [3:0] score_inc(input logic [3:0] score);
        return score + 4'd1;
    endfunction

endpackage

// File: rtl/serve_timer.sv
// Loadable frame down-counter that holds the ball at centre before a serve;
// done fires on the tick that finds the count already at zero.
module serve_timer #(
    parameter logic [9:0] LOAD_VALUE = 10'd59
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic tick,
    output logic done
);

    logic [9:0] count_r;

    // Down-counter: load wins over tick, and the count parks at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= 10'd0;
        end else if (load) begin
            count_r <= LOAD_VALUE;
        end else if (tick && (count_r != 10'd0)) begin
            count_r <= count_r - 10'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign done = tick & (count_r == 10'd0);

endmodule

// File: rtl/game_ctrl.sv
// Match controller for a two-player paddle game: serve timing, scoring,
// win detection and restart, with all outputs driven straight from flops.
module game_ctrl import game_pkg::*; #(
    parameter logic [3:0] WIN_SCORE    = WIN_SCORE_DEF,
    parameter int         SERVE_FRAMES = SERVE_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timing_tick,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] state,
    output logic [3:0] player1_score,
    output logic [3:0] player2_score,
    output logic       ball_rst,
    output logic       serve_dir,
    output logic       winner
);

    game_state_t state_r, next_state_s;
    logic [3:0]  p1_r, p2_r, p1_next_s, p2_next_s;
    logic        ball_rst_r, dir_r, winner_r;
    logic        dir_next_s, winner_next_s, ball_rst_next_s;
    logic        start_q_r, start_rise_s;
    logic        load_s, timer_tick_s, timer_done_s;
    logic [3:0]  p1_inc_s, p2_inc_s;

    assign start_rise_s = start & ~start_q_r;
    assign timer_tick_s = timing_tick & (state_r == ST_SERVE);
    assign p1_inc_s     = score_inc(p1_r);
    assign p2_inc_s     = score_inc(p2_r);

    serve_timer #(
        .LOAD_VALUE(10'(SERVE_FRAMES - 1))
    ) u_serve_timer (
        .clk (clk),
        .rst (rst),
        .load(load_s),
        .tick(timer_tick_s),
        .done(timer_done_s)
    );

    // State and output registers; start_q resets high so a held button is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            p1_r       <= 4'd0;
            p2_r       <= 4'd0;
            ball_rst_r <= 1'b1;
            dir_r      <= 1'b1;
            winner_r   <= 1'b0;
            start_q_r  <= 1'b1;
        end else begin
            state_r    <= next_state_s;
            p1_r       <= p1_next_s;
            p2_r       <= p2_next_s;
            ball_rst_r <= ball_rst_next_s;
            dir_r      <= dir_next_s;
            winner_r   <= winner_next_s;
            start_q_r  <= start;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        next_state_s  = state_r;
        p1_next_s     = p1_r;
        p2_next_s     = p2_r;
        dir_next_s    = dir_r;
        winner_next_s = winner_r;
        load_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                p1_next_s = 4'd0;
                p2_next_s = 4'd0;
                if (start_rise_s) begin
                    next_state_s = ST_SERVE;
                    dir_next_s   = 1'b1;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                if (timer_done_s) begin
                    next_state_s = ST_PLAY;
                end else begin
                    next_state_s = ST_SERVE;
                end
            end
            ST_PLAY: begin
                if (miss_left && miss_right) begin
                    dir_next_s   = ~dir_r;
                    next_state_s = ST_SERVE;
                    load_s       = 1'b1;
                end else if (miss_left) begin
                    p2_next_s  = p2_inc_s;
                    dir_next_s = 1'b0;
                    if (p2_inc_s == WIN_SCORE) begin
                        next_state_s  = ST_OVER;
                        winner_next_s = 1'b1;
                    end else begin
                        next_state_s = ST_SERVE;
                        load_s       = 1'b1;
                    end
                end else if (miss_right) begin
                    p1_next_s  = p1_inc_s;
                    dir_next_s = 1'b1;
                    if (p1_inc_s == WIN_SCORE) begin
                        next_state_s  = ST_OVER;
                        winner_next_s = 1'b0;
                    end else begin
                        next_state_s = ST_SERVE;
                        load_s       = 1'b1;
                    end
                end else begin
                    next_state_s = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (start_rise_s) begin
                    p1_next_s    = 4'd0;
                    p2_next_s    = 4'd0;
                    dir_next_s   = 1'b1;
                    next_state_s = ST_SERVE;
                    load_s       = 1'b1;
                end else begin
                    next_state_s = ST_OVER;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        ball_rst_next_s = (next_state_s != ST_PLAY);
    end

    assign state         = state_r;
    assign player1_score = p1_r;
    assign player2_score = p2_r;
    assign ball_rst      = ball_rst_r;
    assign serve_dir     = dir_r;
    assign winner        = winner_r;

endmodule
